// File: rtl/mux_demux_unit.sv
// rtl/mux_demux_unit.sv - registered 2:1 mux and 1:2 demux on a shared select, with saturating route counters
module mux_demux_unit #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] din,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y_mux,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic             y0_valid,
   output logic             y1_valid,
   output logic [CNT_W-1:0] cnt_y0,
   output logic [CNT_W-1:0] cnt_y1
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] y_mux_q, y_mux_d;
   logic [WIDTH-1:0] y0_q, y0_d;
   logic [WIDTH-1:0] y1_q, y1_d;
   logic             y0_valid_q, y0_valid_d;
   logic             y1_valid_q, y1_valid_d;
   logic [CNT_W-1:0] cnt_y0_q, cnt_y0_d;
   logic [CNT_W-1:0] cnt_y1_q, cnt_y1_d;
   logic             route_y1;

   // Only a definite 1 steers to b/y1; 0, X and Z all fall through to the a/y0 path.
   always_comb begin
      route_y1 = 1'b0;
      if (sel) begin
         route_y1 = 1'b1;
      end
   end

   always_comb begin
      y_mux_d    = y_mux_q;
      y0_d       = y0_q;
      y1_d       = y1_q;
      y0_valid_d = 1'b0;
      y1_valid_d = 1'b0;
      cnt_y0_d   = cnt_y0_q;
      cnt_y1_d   = cnt_y1_q;
      if (in_valid) begin
         if (route_y1) begin
            y_mux_d    = b;
            y0_d       = '0;
            y1_d       = din;
            y1_valid_d = 1'b1;
            if (cnt_y1_q != CNT_MAX) begin
               cnt_y1_d = cnt_y1_q + 1'b1;
            end
         end else begin
            y_mux_d    = a;
            y0_d       = din;
            y1_d       = '0;
            y0_valid_d = 1'b1;
            if (cnt_y0_q != CNT_MAX) begin
               cnt_y0_d = cnt_y0_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_mux_q    <= '0;
         y0_q       <= '0;
         y1_q       <= '0;
         y0_valid_q <= 1'b0;
         y1_valid_q <= 1'b0;
         cnt_y0_q   <= '0;
         cnt_y1_q   <= '0;
      end else begin
         y_mux_q    <= y_mux_d;
         y0_q       <= y0_d;
         y1_q       <= y1_d;
         y0_valid_q <= y0_valid_d;
         y1_valid_q <= y1_valid_d;
         cnt_y0_q   <= cnt_y0_d;
         cnt_y1_q   <= cnt_y1_d;
      end
   end

   assign y_mux    = y_mux_q;
   assign y0       = y0_q;
   assign y1       = y1_q;
   assign y0_valid = y0_valid_q;
   assign y1_valid = y1_valid_q;
   assign cnt_y0   = cnt_y0_q;
   assign cnt_y1   = cnt_y1_q;

endmodule

// File: tb/tb_mux_demux_unit.sv
// tb/tb_mux_demux_unit.sv - directed self-checking bench for mux_demux_unit
module tb_mux_demux_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sel;
   logic       in_valid;
   logic       a, b, din;
   logic [7:0] a8, b8, din8;

   logic       y_mux, y0, y1, y0_valid, y1_valid;
   logic [7:0] cnt_y0, cnt_y1;
   logic [7:0] y_mux_w, y0_w, y1_w;
   logic       y0_valid_w, y1_valid_w;
   logic [1:0] cnt_y0_w, cnt_y1_w;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mux_demux_unit #(.WIDTH(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .din(din), .sel(sel), .in_valid(in_valid),
      .y_mux(y_mux), .y0(y0), .y1(y1), .y0_valid(y0_valid), .y1_valid(y1_valid),
      .cnt_y0(cnt_y0), .cnt_y1(cnt_y1)
   );

   mux_demux_unit #(.WIDTH(8), .CNT_W(2)) u_wide (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .din(din8), .sel(sel), .in_valid(in_valid),
      .y_mux(y_mux_w), .y0(y0_w), .y1(y1_w), .y0_valid(y0_valid_w), .y1_valid(y1_valid_w),
      .cnt_y0(cnt_y0_w), .cnt_y1(cnt_y1_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; sel = 1'b1;
      a = 1'b1; b = 1'b1; din = 1'b1;
      a8 = 8'hC3; b8 = 8'h7E; din8 = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if ({y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_main edge%0d got %b exp 0", i, {y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1});
         end
         tests_run++;
         if ({y_mux_w, y0_w, y1_w, y0_valid_w, y1_valid_w, cnt_y0_w, cnt_y1_w} !== 30'd0) begin
            tests_failed++;
            $display("FAIL reset_wide edge%0d got %h exp 0", i, {y_mux_w, y0_w, y1_w, y0_valid_w, y1_valid_w, cnt_y0_w, cnt_y1_w});
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      tests_run++;
      if ({y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1, y_mux_w, y0_w, y1_w, cnt_y0_w, cnt_y1_w} !== 49'd0) begin
         tests_failed++;
         $display("FAIL reset_release got nonzero state exp all 0");
      end
   endtask

   task automatic test_mux_select();
      logic       va [4];
      logic       vb [4];
      logic       vs [4];
      logic       exp_y [4];
      logic [7:0] exp_w [4];
      va = '{1'b0, 1'b0, 1'b1, 1'b1};
      vb = '{1'b1, 1'b1, 1'b0, 1'b0};
      vs = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_y = '{1'b0, 1'b1, 1'b1, 1'b0};
      exp_w = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      a8 = 8'hA5; b8 = 8'h3C; din8 = 8'h00; din = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i]; sel = vs[i];
         tick();
         tests_run++;
         if (y_mux !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL mux_step%0d y_mux got %b exp %b", i, y_mux, exp_y[i]);
         end
         tests_run++;
         if (y_mux_w !== exp_w[i]) begin
            tests_failed++;
            $display("FAIL mux_wide_step%0d y_mux got %h exp %h", i, y_mux_w, exp_w[i]);
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if ({cnt_y0, cnt_y1} !== {8'd2, 8'd2}) begin
         tests_failed++;
         $display("FAIL mux_counts got %0d/%0d exp 2/2", cnt_y0, cnt_y1);
      end
   endtask

   task automatic test_demux_routing();
      do_reset();
      a = 1'b0; b = 1'b1; din = 1'b1; in_valid = 1'b1;
      a8 = 8'h11; b8 = 8'h22; din8 = 8'h96; sel = 1'b0;
      tick();
      tests_run++;
      if ({y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1} !== {4'b1010, 8'd1, 8'd0}) begin
         tests_failed++;
         $display("FAIL demux_sel0 got %b exp %b", {y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1}, {4'b1010, 8'd1, 8'd0});
      end
      tests_run++;
      if ({y0_w, y1_w} !== 16'h9600) begin
         tests_failed++;
         $display("FAIL demux_wide_sel0 got %h exp 9600", {y0_w, y1_w});
      end
      sel = 1'b1; din8 = 8'h5A;
      tick();
      tests_run++;
      if ({y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1} !== {4'b0101, 8'd1, 8'd1}) begin
         tests_failed++;
         $display("FAIL demux_sel1 got %b exp %b", {y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1}, {4'b0101, 8'd1, 8'd1});
      end
      tests_run++;
      if ({y0_w, y1_w, y_mux_w} !== 24'h005A22) begin
         tests_failed++;
         $display("FAIL demux_wide_sel1 got %h exp 005a22", {y0_w, y1_w, y_mux_w});
      end
   endtask

   task automatic test_idle_hold();
      in_valid = 1'b0;
      sel = 1'b0; a = 1'b0; b = 1'b0; din = 1'b0;
      a8 = 8'hEE; b8 = 8'hDD; din8 = 8'hCC;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if ({y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1} !== {5'b10100, 8'd1, 8'd1}) begin
            tests_failed++;
            $display("FAIL idle_edge%0d got %b exp %b", i, {y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1}, {5'b10100, 8'd1, 8'd1});
         end
         tests_run++;
         if ({y_mux_w, y0_w, y1_w, y0_valid_w, y1_valid_w} !== {24'h22005A, 2'b00}) begin
            tests_failed++;
            $display("FAIL idle_wide_edge%0d got %h exp %h", i, {y_mux_w, y0_w, y1_w, y0_valid_w, y1_valid_w}, {24'h22005A, 2'b00});
         end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat [5];
      logic [7:0] exp_main [5];
      logic [7:0] data [5];
      exp_sat  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_main = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      data     = '{8'h01, 8'h80, 8'h7F, 8'hFE, 8'h33};
      do_reset();
      sel = 1'b0; in_valid = 1'b1; din = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din8 = data[i];
         tick();
         tests_run++;
         if ({cnt_y0_w, cnt_y1_w, y0_valid_w, y1_valid_w, y0_w} !== {exp_sat[i], 2'd0, 2'b10, data[i]}) begin
            tests_failed++;
            $display("FAIL sat_step%0d got cnt0=%0d cnt1=%0d v=%b%b y0=%h exp cnt0=%0d cnt1=0 v=10 y0=%h",
                     i, cnt_y0_w, cnt_y1_w, y0_valid_w, y1_valid_w, y0_w, exp_sat[i], data[i]);
         end
         tests_run++;
         if (cnt_y0 !== exp_main[i]) begin
            tests_failed++;
            $display("FAIL sat_main_step%0d cnt_y0 got %0d exp %0d", i, cnt_y0, exp_main[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       vs [4];
      logic [7:0] e0 [4];
      logic [7:0] e1 [4];
      logic [1:0] w0 [4];
      logic [1:0] w1 [4];
      vs = '{1'b1, 1'b0, 1'b1, 1'b0};
      e0 = '{8'd5, 8'd6, 8'd6, 8'd7};
      e1 = '{8'd1, 8'd1, 8'd2, 8'd2};
      w0 = '{2'd3, 2'd3, 2'd3, 2'd3};
      w1 = '{2'd1, 2'd1, 2'd2, 2'd2};
      in_valid = 1'b1; din = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = vs[i];
         tick();
         tests_run++;
         if ({y0_valid, y1_valid, cnt_y0, cnt_y1} !== {~vs[i], vs[i], e0[i], e1[i]}) begin
            tests_failed++;
            $display("FAIL b2b_step%0d got v=%b%b cnt=%0d/%0d exp v=%b%b cnt=%0d/%0d",
                     i, y0_valid, y1_valid, cnt_y0, cnt_y1, ~vs[i], vs[i], e0[i], e1[i]);
         end
         tests_run++;
         if ({cnt_y0_w, cnt_y1_w} !== {w0[i], w1[i]}) begin
            tests_failed++;
            $display("FAIL b2b_wide_step%0d got cnt=%0d/%0d exp %0d/%0d", i, cnt_y0_w, cnt_y1_w, w0[i], w1[i]);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      rst_n = 1'b0; in_valid = 1'b1; sel = 1'b1; din = 1'b1; b = 1'b1; din8 = 8'h44; b8 = 8'h55;
      tick();
      tests_run++;
      if ({y_mux, y0, y1, y0_valid, y1_valid, cnt_y0, cnt_y1, y_mux_w, y0_w, y1_w, y0_valid_w, y1_valid_w, cnt_y0_w, cnt_y1_w} !== 51'd0) begin
         tests_failed++;
         $display("FAIL reset_mid got nonzero state exp all 0");
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if ({y_mux, y1, y1_valid, cnt_y0, cnt_y1} !== {3'b111, 8'd0, 8'd1}) begin
         tests_failed++;
         $display("FAIL reset_mid_next got %b exp %b", {y_mux, y1, y1_valid, cnt_y0, cnt_y1}, {3'b111, 8'd0, 8'd1});
      end
      tests_run++;
      if ({y1_w, cnt_y0_w, cnt_y1_w} !== {8'h44, 2'd0, 2'd1}) begin
         tests_failed++;
         $display("FAIL reset_mid_wide got %h exp %h", {y1_w, cnt_y0_w, cnt_y1_w}, {8'h44, 2'd0, 2'd1});
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0;
      a = 1'b0; b = 1'b0; din = 1'b0;
      a8 = 8'h00; b8 = 8'h00; din8 = 8'h00;
      test_reset();
      test_mux_select();
      test_demux_routing();
      test_idle_hold();
      test_saturation();
      test_back_to_back();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mux_demux_unit.md
Name: mux_demux_unit

Overview:
- Clocked pair of selectors sharing one select line.
- 2:1 multiplexer: picks operand a or b onto y_mux.
- 1:2 demultiplexer: routes din to y0 or y1; the unselected output is driven to zero.
- Outputs are registered, qualified by an input valid, and backed by saturating per-route transfer counters for datapath steering and debug visibility.

Parameters:
- WIDTH, 1, bit width of a, b, din, y_mux, y0, y1.
- CNT_W, 8, bit width of each transfer counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- a, input, WIDTH, mux operand selected when sel=0.
- b, input, WIDTH, mux operand selected when sel=1.
- din, input, WIDTH, demux data input.
- sel, input, 1, shared select for mux and demux.
- in_valid, input, 1, qualifies a, b, din, sel for capture this cycle.
- y_mux, output, WIDTH, registered mux result.
- y0, output, WIDTH, registered demux output 0.
- y1, output, WIDTH, registered demux output 1.
- y0_valid, output, 1, one-cycle pulse: y0 was loaded with din.
- y1_valid, output, 1, one-cycle pulse: y1 was loaded with din.
- cnt_y0, output, CNT_W, saturating count of transfers routed to y0.
- cnt_y1, output, CNT_W, saturating count of transfers routed to y1.

Behaviour:
- All outputs are registers. There is no combinational path from input to output.
- Reset: on a rising clk edge with rst_n=0, these outputs go to 0 regardless of other inputs:
  - y_mux, y0, y1
  - y0_valid, y1_valid
  - cnt_y0, cnt_y1
- Reset is synchronous only. Asserting rst_n mid-operation takes effect at the next edge. It discards any capture on that edge and clears the counters.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - y_mux <= (sel==1) ? b : a.
  - sel=0: y0 <= din, y1 <= 0, y0_valid <= 1, y1_valid <= 0. cnt_y0 increments.
  - sel=1: y1 <= din, y0 <= 0, y1_valid <= 1, y0_valid <= 0. cnt_y1 increments.
- Latency: exactly 1 cycle from input capture to output.
- Back-to-back captures are supported every cycle; throughput is 1 per clock.
- Idle: on a rising edge with rst_n=1 and in_valid=0:
  - y_mux, y0, y1 hold their previous values.
  - y0_valid and y1_valid go to 0.
  - Counters hold.
- Select decoding: only logic 1 selects the b / y1 path. 0, X or Z selects the a / y0 path, with no X propagation into counters.
- Counters:
  - Unsigned, increment by 1 per routed transfer.
  - Saturate at 2^CNT_W-1 and never wrap.
  - A transfer when saturated leaves the count unchanged but still updates data and valid outputs.
- Mutual exclusion: y0_valid and y1_valid are never both 1. At most one counter changes per cycle.
- Simultaneous change of sel and data in the same cycle is captured as a consistent set at the edge.
- Width: data passes through unmodified. No sign extension, truncation or arithmetic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs and in_valid=1 -> all outputs and counters 0. Release -> outputs stay 0 until the first valid capture.
- Mux select, WIDTH=1: a=0, b=1, in_valid=1.
  - sel=0 -> y_mux=0 after 1 edge.
  - sel=1 -> y_mux=1 after the next edge.
  - Repeat with a=1, b=0 -> y_mux follows a, then b.
- Demux routing: din=1, in_valid=1.
  - sel=0 -> y0=1, y1=0, y0_valid=1, cnt_y0=1.
  - Then sel=1 -> y0=0, y1=1, y1_valid=1, cnt_y1=1.
- Idle hold: after a capture, drop in_valid for 3 edges -> y_mux/y0/y1 unchanged, valids 0, counters unchanged.
- Saturation, CNT_W=2: 5 consecutive sel=0 transfers -> cnt_y0 sequence 1, 2, 3, 3, 3; y0_valid=1 on every one; cnt_y1 stays 0.
- Reset mid-stream: counters at nonzero values, assert rst_n=0 for 1 edge alongside in_valid=1 -> all outputs 0 with no capture. Next valid transfer yields count 1.
